music_feeder: RTL and testbench
===============================

Name: music_feeder

Overview:
- Front end for the beeper music player: turns a byte stream from the UART receiver into (note, duration) pairs.
- Queues the pairs and issues them one at a time to the player through its en / music_note / music_time / music_busy interface.
- Acts as the initiator side of that interface: it holds data stable, pulses en, and waits for busy to rise and fall before issuing the next note.

Parameters:
- DEPTH, 8: number of (note, time) pairs the FIFO holds; power of two, 2..64.
- BYTE_TIMEOUT, 24'd1_200_000: cycles allowed between the note byte and the time byte (100 ms at 12 MHz).
- ACK_TIMEOUT, 16'd64: cycles to wait for music_busy to rise after en asserts.

Ports:
- sys_clk  in  1  system clock, 12 MHz
- sys_rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- music_busy  in  1  player busy, from player
- en  out  1  play request to player
- music_note  out  8  tone code to player
- music_time  out  8  duration in ms to player
- fifo_empty  out  1  no pairs queued
- fifo_full  out  1  DEPTH pairs queued
- overflow  out  1  sticky: a completed pair was dropped because the FIFO was full
- ack_err  out  1  sticky: player failed to raise busy within ACK_TIMEOUT
- frame_err  out  1  sticky: half pair discarded by BYTE_TIMEOUT

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately regardless of clock):
  - en=0, music_note=0, music_time=0.
  - FIFO emptied: fifo_empty=1, fifo_full=0.
  - Sticky flags cleared.
  - Parser returns to EXPECT_NOTE; issuer returns to IDLE.
  - An in-progress player transaction is abandoned, with no further handshake.
- Parser:
  - EXPECT_NOTE: on rx_valid, latch rx_data as the note, clear the byte timer, go to EXPECT_TIME.
  - EXPECT_TIME: the byte timer counts every cycle.
    - On rx_valid, form the pair {note, rx_data}. Write it to the FIFO if not full; otherwise discard it and set overflow. Go to EXPECT_NOTE.
    - If the timer reaches BYTE_TIMEOUT-1 without rx_valid, discard the note, set frame_err, go to EXPECT_NOTE.
    - If rx_valid arrives on the timeout cycle, the byte is accepted as time; the timeout does not fire.
  - A time byte of 0 is legal and is queued as-is.
- FIFO:
  - Synchronous, 16 bits wide (note in [15:8], time in [7:0]), DEPTH entries, wrap-around pointers.
  - Occupancy counter of width log2(DEPTH)+1.
  - Write and pop in the same cycle: both occur and occupancy is unchanged; allowed even when full.
  - Write when full is dropped and sets overflow; the pointer does not advance.
  - Pop is never issued when empty.
  - fifo_empty and fifo_full are registered, valid the cycle after each change.
- Issuer FSM:
  - IDLE: if the FIFO is not empty and music_busy=0, pop the head into music_note/music_time and go to REQ.
  - REQ: assert en; count cycles.
    - When music_busy=1 is sampled, deassert en next cycle and go to WAIT_DONE.
    - If ACK_TIMEOUT cycles pass with busy low, deassert en, set ack_err, go to IDLE; the pair is lost.
  - WAIT_DONE: en=0. When music_busy=0 is sampled, go to IDLE.
  - music_note and music_time hold their values from the pop until the next pop; they never change while en=1 or busy=1.
  - en must drop once busy is seen. The player re-triggers on a level en after finishing, so a held en would replay the note.
  - Minimum gap: at least one IDLE cycle between music_busy falling and the next en.
- Latency:
  - rx_valid of the time byte to fifo_empty=0: 1 cycle.
  - From an empty FIFO and idle player, en asserts 2 cycles after the time-byte strobe (write, then IDLE pop, then REQ).

Test Plan:
- Single pair: reset, send rx 0x05 then 0x0A.
  - en rises 2 cycles after the second strobe with music_note=0x05 and music_time=0x0A.
  - The player model raises busy 2 cycles later; en falls the next cycle.
  - Busy is held low after 10 ms; no second en appears and fifo_empty=1.
- Back-to-back: queue pairs (1,3), (2,3), (3,3) while the player is busy.
  - Exactly three en pulses, in order, each only after busy has fallen.
  - Outputs stay stable throughout each busy window.
- Overflow: stall busy high, send DEPTH+1 pairs.
  - fifo_full=1 after DEPTH pairs; the extra pair is dropped and overflow=1.
  - After release, exactly DEPTH notes play, in order.
- Frame timeout: send 0x07, then nothing for BYTE_TIMEOUT cycles, then 0x08 and 0x09.
  - frame_err=1; the only pair queued is (0x08, 0x09).
- Ack timeout: a player model that never raises busy.
  - en drops after 64 cycles and ack_err=1.
  - The next queued pair is then issued normally.
- Reset mid-transaction: assert sys_rst while in WAIT_DONE with 3 pairs queued.
  - en=0, outputs=0, fifo_empty=1 and all flags=0 immediately, without a clock edge.
  - After release, no en until new bytes arrive.

Source files
------------

// File: rtl/music_feeder.sv
// -----------------------------------------------------------------------------
// music_feeder
//   Front end for the beeper music player. Bytes from the UART receiver are
//   paired up as (note, time), queued in a small FIFO and handed to the player
//   one at a time over an en / music_note / music_time / music_busy handshake.
//
// Ports
//   sys_clk     in   system clock (12 MHz)
//   sys_rst     in   asynchronous, active-high reset
//   rx_data     in   received UART byte
//   rx_valid    in   one-cycle strobe qualifying rx_data
//   music_busy  in   player busy
//   en          out  play request to the player
//   music_note  out  tone code, stable from pop until the next pop
//   music_time  out  duration in ms, stable from pop until the next pop
//   fifo_empty  out  no pairs queued (registered)
//   fifo_full   out  DEPTH pairs queued (registered)
//   overflow    out  sticky: a completed pair was dropped on a full FIFO
//   ack_err     out  sticky: player never raised busy within ACK_TIMEOUT
//   frame_err   out  sticky: a lone note byte was dropped by BYTE_TIMEOUT
// -----------------------------------------------------------------------------
module music_feeder #(
   parameter int          DEPTH        = 8,
   parameter logic [23:0] BYTE_TIMEOUT = 24'd1_200_000,
   parameter logic [15:0] ACK_TIMEOUT  = 16'd64
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       music_busy,
   output logic       en,
   output logic [7:0] music_note,
   output logic [7:0] music_time,
   output logic       fifo_empty,
   output logic       fifo_full,
   output logic       overflow,
   output logic       ack_err,
   output logic       frame_err
);

   localparam int            AW       = $clog2(DEPTH);
   localparam int            CW       = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic       {P_NOTE, P_TIME} parse_t;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DONE} issue_t;

   // parser
   parse_t        pstate_q, pstate_d;
   logic [7:0]    pnote_q, pnote_d;
   logic [23:0]   btmr_q, btmr_d;
   logic          pair_vld;
   logic          frame_set;

   // FIFO
   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          empty_q, full_q;
   logic          wr_en, pop, ovf_set;
   logic [15:0]   head;

   // issuer
   issue_t        istate_q, istate_d;
   logic [15:0]   acnt_q, acnt_d;
   logic          en_q, en_d;
   logic [7:0]    note_q, note_d;
   logic [7:0]    time_q, time_d;
   logic          ack_set;

   // sticky flags
   logic          ovf_q, ack_err_q, frame_err_q;

   // ---------------------------------------------------------------- parser
   always_comb begin
      pstate_d  = pstate_q;
      pnote_d   = pnote_q;
      btmr_d    = btmr_q;
      pair_vld  = 1'b0;
      frame_set = 1'b0;
      case (pstate_q)
         P_NOTE: begin
            if (rx_valid) begin
               pnote_d  = rx_data;
               btmr_d   = '0;
               pstate_d = P_TIME;
            end
         end
         P_TIME: begin
            // A time byte on the very cycle the timer expires still wins.
            if (rx_valid) begin
               pair_vld = 1'b1;
               pstate_d = P_NOTE;
            end else if (btmr_q == BYTE_TIMEOUT - 24'd1) begin
               frame_set = 1'b1;
               pstate_d  = P_NOTE;
            end else begin
               btmr_d = btmr_q + 24'd1;
            end
         end
         default: pstate_d = P_NOTE;
      endcase
   end

   // ------------------------------------------------------------------ FIFO
   // A write on a full FIFO still lands if the issuer pops in the same cycle.
   always_comb begin
      wr_en   = pair_vld & (~full_q | pop);
      ovf_set = pair_vld & full_q & ~pop;
      wptr_d  = wr_en ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop   ? rptr_q + AW'(1) : rptr_q;
      cnt_d   = cnt_q + CW'(wr_en) - CW'(pop);
   end

   assign head = mem_q[rptr_q];

   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= {pnote_q, rx_data};
      end
   end

   // ---------------------------------------------------------------- issuer
   always_comb begin
      istate_d = istate_q;
      acnt_d   = acnt_q;
      en_d     = 1'b0;
      note_d   = note_q;
      time_d   = time_q;
      pop      = 1'b0;
      ack_set  = 1'b0;
      case (istate_q)
         S_IDLE: begin
            // Waiting for busy low here also gives the mandatory idle cycle
            // after a finished note before the next en.
            if (!empty_q && !music_busy) begin
               pop      = 1'b1;
               note_d   = head[15:8];
               time_d   = head[7:0];
               acnt_d   = '0;
               en_d     = 1'b1;
               istate_d = S_REQ;
            end
         end
         S_REQ: begin
            // en must drop as soon as busy is seen or the player replays.
            if (music_busy) begin
               istate_d = S_WAIT_DONE;
            end else if (acnt_q == ACK_TIMEOUT - 16'd1) begin
               ack_set  = 1'b1;
               istate_d = S_IDLE;
            end else begin
               en_d   = 1'b1;
               acnt_d = acnt_q + 16'd1;
            end
         end
         S_WAIT_DONE: begin
            if (!music_busy) begin
               istate_d = S_IDLE;
            end
         end
         default: istate_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------- registers
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pstate_q    <= P_NOTE;
         pnote_q     <= '0;
         btmr_q      <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         istate_q    <= S_IDLE;
         acnt_q      <= '0;
         en_q        <= 1'b0;
         note_q      <= '0;
         time_q      <= '0;
         ovf_q       <= 1'b0;
         ack_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         pstate_q    <= pstate_d;
         pnote_q     <= pnote_d;
         btmr_q      <= btmr_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         cnt_q       <= cnt_d;
         empty_q     <= (cnt_d == '0);
         full_q      <= (cnt_d == FULL_CNT);
         istate_q    <= istate_d;
         acnt_q      <= acnt_d;
         en_q        <= en_d;
         note_q      <= note_d;
         time_q      <= time_d;
         ovf_q       <= ovf_q | ovf_set;
         ack_err_q   <= ack_err_q | ack_set;
         frame_err_q <= frame_err_q | frame_set;
      end
   end

   assign en         = en_q;
   assign music_note = note_q;
   assign music_time = time_q;
   assign fifo_empty = empty_q;
   assign fifo_full  = full_q;
   assign overflow   = ovf_q;
   assign ack_err    = ack_err_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_music_feeder.sv
// -----------------------------------------------------------------------------
// tb_music_feeder
//   Drives byte streams into music_feeder, models the beeper player on the
//   busy side, and predicts the issued note sequence with a simple queue.
// -----------------------------------------------------------------------------
module tb_music_feeder;

   localparam int          DEPTH  = 8;
   localparam logic [23:0] BT     = 24'd200;
   localparam logic [15:0] ACK_TO = 16'd64;

   localparam int M_NORMAL = 0;
   localparam int M_STALL  = 1;
   localparam int M_NEVER  = 2;

   logic       sys_clk, sys_rst, rx_valid, music_busy;
   logic [7:0] rx_data, music_note, music_time;
   logic       en, fifo_empty, fifo_full, overflow, ack_err, frame_err;

   int          n_chk = 0;
   int          n_fail = 0;
   int          pmode;
   int          play_len;
   bit          txn_fall;
   int          n_issued;
   logic [15:0] exp_q[$];

   music_feeder #(
      .DEPTH(DEPTH), .BYTE_TIMEOUT(BT), .ACK_TIMEOUT(ACK_TO)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data),
      .rx_valid(rx_valid), .music_busy(music_busy), .en(en),
      .music_note(music_note), .music_time(music_time),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow),
      .ack_err(ack_err), .frame_err(frame_err)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      repeat (50000) @(posedge sys_clk);
      $display("FAIL watchdog: test did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   // ---------------------------------------------------------------- player
   // Raises busy two cycles after seeing en, holds it play_len cycles.
   initial begin
      music_busy = 1'b0;
      txn_fall   = 1'b0;
      forever begin
         @(posedge sys_clk); #1;
         if (pmode == M_STALL) begin
            music_busy = 1'b1;
            txn_fall   = 1'b0;
         end else if (pmode == M_NORMAL && en && !music_busy) begin
            repeat (2) @(posedge sys_clk);
            #1 music_busy = 1'b1;
            repeat (play_len) @(posedge sys_clk);
            #1 music_busy = 1'b0;
            txn_fall = 1'b1;
         end else begin
            music_busy = 1'b0;
         end
      end
   end

   // --------------------------------------------------------------- monitor
   initial begin
      logic        en_p, busy_p1, busy_p2, hold_v, busy_in_pulse;
      logic [7:0]  held_n, held_t;
      logic [15:0] e;
      int          en_len;
      en_p = 0; busy_p1 = 0; busy_p2 = 0; hold_v = 0; busy_in_pulse = 0;
      held_n = 0; held_t = 0; en_len = 0; n_issued = 0;
      forever begin
         @(negedge sys_clk);
         if (sys_rst) begin
            hold_v = 0;
            en_len = 0;
         end else begin
            if (en && !en_p) begin
               n_issued++;
               check_val("issue_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check_val("issue_note", music_note, e[15:8]);
                  check_val("issue_time", music_time, e[7:0]);
               end
               if (txn_fall) check_val("issue_gap", {busy_p2, busy_p1}, 0);
               held_n = music_note; held_t = music_time;
               hold_v = 1; en_len = 0; busy_in_pulse = 0;
            end
            if (en) begin
               en_len++;
               if (music_busy) busy_in_pulse = 1;
            end
            if (en_p && busy_p1) check_val("en_drop", en, 0);
            if (!en && en_p && !busy_in_pulse) check_val("ack_len", en_len, ACK_TO);
            if (hold_v && (en || music_busy)) begin
               check_val("hold_note", music_note, held_n);
               check_val("hold_time", music_time, held_t);
            end else if (!en && !music_busy) begin
               hold_v = 0;
            end
         end
         en_p = en; busy_p2 = busy_p1; busy_p1 = music_busy;
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(posedge sys_clk);
      @(posedge sys_clk); #1;
      rx_data = b; rx_valid = 1'b1;
      @(posedge sys_clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_pair(input logic [7:0] n, input logic [7:0] t, input int gap);
      exp_q.push_back({n, t});
      send_byte(n, 0);
      send_byte(t, gap);
   endtask

   task automatic wait_busy(input logic lvl, input int maxc, input string tag);
      for (int i = 0; i < maxc; i++) begin
         @(negedge sys_clk);
         if (music_busy == lvl) break;
      end
      check_val(tag, music_busy, lvl);
   endtask

   task automatic wait_en(input logic lvl, input int maxc, input string tag);
      for (int i = 0; i < maxc; i++) begin
         @(negedge sys_clk);
         if (en == lvl) break;
      end
      check_val(tag, en, lvl);
   endtask

   task automatic drain(input int maxc, input string tag);
      int q = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge sys_clk);
         if (fifo_empty && !en && !music_busy) q++;
         else q = 0;
         if (q >= 4) break;
      end
      check_val(tag, 32'(q >= 4), 1);
   endtask

   task automatic check_reset_state(input string pfx);
      check_val({pfx, "_en"}, en, 0);
      check_val({pfx, "_note"}, music_note, 0);
      check_val({pfx, "_time"}, music_time, 0);
      check_val({pfx, "_empty"}, fifo_empty, 1);
      check_val({pfx, "_full"}, fifo_full, 0);
      check_val({pfx, "_ovf"}, overflow, 0);
      check_val({pfx, "_ackerr"}, ack_err, 0);
      check_val({pfx, "_frameerr"}, frame_err, 0);
   endtask

   // ------------------------------------------------------------------ main
   initial begin
      int         base, sent;
      logic [7:0] rn, rt;
      sys_rst = 1'b0; rx_data = '0; rx_valid = 1'b0;
      pmode = M_NORMAL; play_len = 3;
      #1 sys_rst = 1'b1;
      #1 check_reset_state("rst0");
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk); sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      // single pair with latency
      base = n_issued;
      exp_q.push_back(16'h050A);
      send_byte(8'h05, 0);
      send_byte(8'h0A, 0);
      check_val("lat_empty", fifo_empty, 0);
      check_val("lat_en_early", en, 0);
      @(posedge sys_clk); #1;
      check_val("lat_en", en, 1);
      check_val("lat_note", music_note, 8'h05);
      check_val("lat_time", music_time, 8'h0A);
      drain(500, "single_drain");
      repeat (100) @(negedge sys_clk);
      check_val("single_count", n_issued - base, 1);
      check_val("single_empty", fifo_empty, 1);

      // back-to-back while busy
      base = n_issued; play_len = 30;
      send_pair(8'h40, 8'h10, 0);
      wait_busy(1, 50, "b2b_busy");
      send_pair(8'h01, 8'h03, 0);
      send_pair(8'h02, 8'h03, 0);
      send_pair(8'h03, 8'h03, 0);
      drain(1000, "b2b_drain");
      check_val("b2b_count", n_issued - base, 4);

      // byte timeout: boundary accepted, one cycle later discarded
      base = n_issued; play_len = 5;
      check_val("frame_pre", frame_err, 0);
      send_pair(8'h21, 8'h22, int'(BT) - 2);
      check_val("frame_edge", frame_err, 0);
      send_byte(8'h07, 0);
      send_byte(8'h08, int'(BT) - 1);
      check_val("frame_set", frame_err, 1);
      exp_q.push_back(16'h0809);
      send_byte(8'h09, 0);
      drain(1000, "frame_drain");
      check_val("frame_count", n_issued - base, 2);

      // ack timeout, then normal issue of the next pair
      base = n_issued; pmode = M_NEVER;
      check_val("ack_pre", ack_err, 0);
      send_pair(8'h31, 8'h32, 0);
      send_pair(8'h33, 8'h34, 0);
      wait_en(1, 20, "ack_en_up");
      wait_en(0, int'(ACK_TO) + 10, "ack_en_down");
      pmode = M_NORMAL;
      check_val("ack_set", ack_err, 1);
      drain(500, "ack_drain");
      check_val("ack_count", n_issued - base, 2);

      // overflow with a stalled player
      pmode = M_STALL;
      repeat (3) @(posedge sys_clk);
      base = n_issued;
      check_val("ovf_pre", overflow, 0);
      for (int k = 0; k <= DEPTH; k++) begin
         if (k < DEPTH) exp_q.push_back({8'(8'h80 + k), 8'(8'h10 + k)});
         send_byte(8'(8'h80 + k), 0);
         send_byte(8'(8'h10 + k), 0);
         if (k == DEPTH - 2) check_val("ovf_notfull", fifo_full, 0);
         if (k == DEPTH - 1) begin
            check_val("ovf_full", fifo_full, 1);
            check_val("ovf_notyet", overflow, 0);
         end
         if (k == DEPTH) check_val("ovf_set", overflow, 1);
      end
      play_len = 3; pmode = M_NORMAL;
      drain(2000, "ovf_drain");
      check_val("ovf_count", n_issued - base, DEPTH);

      // randomized traffic, never more than DEPTH-1 pairs outstanding
      base = n_issued; sent = 0;
      for (int i = 0; i < 30; i++) begin
         for (int k = 0; k < 2000; k++) begin
            if (sent - (n_issued - base) <= DEPTH - 2) break;
            @(negedge sys_clk);
         end
         play_len = int'($urandom_range(1, 12));
         rn = 8'($urandom);
         rt = (i % 7 == 0) ? 8'h00 : 8'($urandom);
         exp_q.push_back({rn, rt});
         send_byte(rn, int'($urandom_range(0, 6)));
         send_byte(rt, int'($urandom_range(0, 20)));
         sent++;
      end
      drain(3000, "rand_drain");
      check_val("rand_count", n_issued - base, 30);
      check_val("rand_queue", exp_q.size(), 0);

      // reset while waiting for a long note to finish
      base = n_issued; play_len = 80;
      send_pair(8'h50, 8'h51, 0);
      wait_busy(1, 50, "rst_busy_up");
      send_pair(8'h52, 8'h53, 0);
      send_pair(8'h54, 8'h55, 0);
      send_pair(8'h56, 8'h57, 0);
      @(negedge sys_clk);
      check_val("rst_pre_en", en, 0);
      check_val("rst_pre_busy", music_busy, 1);
      check_val("rst_pre_empty", fifo_empty, 0);
      check_val("sticky_ovf", overflow, 1);
      check_val("sticky_ack", ack_err, 1);
      check_val("sticky_frame", frame_err, 1);
      #2 sys_rst = 1'b1;
      #1 check_reset_state("rst_mid");
      exp_q.delete();
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk); sys_rst = 1'b0;
      repeat (120) @(negedge sys_clk);
      check_val("rst_no_en", n_issued - base, 1);
      check_val("rst_post_empty", fifo_empty, 1);
      base = n_issued; play_len = 3;
      send_pair(8'h60, 8'h61, 0);
      drain(500, "rst_post_drain");
      check_val("rst_post_count", n_issued - base, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
